// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: IDLE/FETCH/DECODE/EXEC/MEM/WB control FSM
// with program counter, latched instruction and retired-instruction counter.
module instr_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] instruction,
    input  logic       mem_ready,
    output logic [7:0] pc,
    output logic [7:0] instr_q,
    output logic [2:0] state,
    output logic       mem_req,
    output logic       mem_we,
    output logic       reg_we,
    output logic [1:0] reg_wsel,
    output logic       wb_sel,
    output logic       busy,
    output logic [7:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_e;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] retired_q, retired_d;
    logic [1:0] opcode_s;
    logic [7:0] pc_offset_s;

    assign opcode_s = ir_q[7:6];
    // Jump immediate is a 2-bit two's-complement value added on top of the +1.
    assign pc_offset_s = (opcode_s == OP_JMP) ? {{6{ir_q[1]}}, ir_q[1:0]} : 8'd0;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (run || step) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                if ((opcode_s == OP_LW) || (opcode_s == OP_SW)) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                if (mem_ready) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_MEM;
                end
            end
            S_WB: begin
                if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath registers: instruction latch, pc and retired counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q      <= 8'd0;
            ir_q      <= 8'd0;
            retired_q <= 8'd0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    // Datapath next values; pc and retired only move on the WB exit edge
    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        if (state_q == S_FETCH) begin
            ir_d = instruction;
        end else if (state_q == S_WB) begin
            pc_d      = pc_q + 8'd1 + pc_offset_s;
            retired_d = retired_q + 8'd1;
        end else begin
            ir_d = ir_q;
        end
    end

    // Output decode from state and latched instruction only
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        reg_we   = 1'b0;
        busy     = 1'b1;
        wb_sel   = (opcode_s == OP_LW);
        reg_wsel = (opcode_s == OP_ADD) ? ir_q[1:0] : ir_q[3:2];
        case (state_q)
            S_IDLE: busy = 1'b0;
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = (opcode_s == OP_SW);
            end
            S_WB: reg_we = (opcode_s == OP_ADD) || (opcode_s == OP_LW);
            default: busy = 1'b1;
        endcase
    end

    assign pc      = pc_q;
    assign instr_q = ir_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed table, hand-written
// run/step and reset-abort sequences, and random instructions vs. a transaction model.
module tb_instr_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       run = 1'b0;
    logic       step = 1'b0;
    logic [7:0] instruction = 8'd0;
    logic       mem_ready = 1'b0;
    logic [7:0] pc, instr_q, retired;
    logic [2:0] state;
    logic       mem_req, mem_we, reg_we, wb_sel, busy;
    logic [1:0] reg_wsel;

    instr_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .step(step),
        .instruction(instruction), .mem_ready(mem_ready),
        .pc(pc), .instr_q(instr_q), .state(state),
        .mem_req(mem_req), .mem_we(mem_we), .reg_we(reg_we),
        .reg_wsel(reg_wsel), .wb_sel(wb_sel), .busy(busy), .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         rst;
        logic [7:0] ins;
        int         waits;
        int         lat;
        logic [7:0] pc;
        logic [7:0] ret;
        int         mreq;
        int         mwe;
        int         rwe;
        logic       wbs;
        logic [1:0] wsel;
    } vec_t;

    vec_t vecs[11];
    int   n_cmp = 0;
    int   n_err = 0;

    // observations of one instruction
    int   obs_q[$];
    int   o_mreq, o_mwe, o_rwe, o_rwe_out, o_busy_err;
    logic o_wbs;
    logic [1:0] o_wsel;
    bit   o_timeout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        step = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Start one instruction with a step pulse and observe it until IDLE.
    task automatic run_one(input logic [7:0] ins, input int waits, input bit noise);
        int  mem_seen;
        bit  done;
        obs_q.delete();
        o_mreq = 0; o_mwe = 0; o_rwe = 0; o_rwe_out = 0; o_busy_err = 0;
        o_wbs = 1'b0; o_wsel = 2'd0; o_timeout = 1'b0;
        instruction = ins;
        step = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        step = 1'b0;
        mem_seen = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            if (busy !== (state != 3'd0)) o_busy_err++;
            if (state == 3'd0) begin
                done = 1'b1;
            end else begin
                obs_q.push_back(int'(state));
                o_mreq += int'(mem_req);
                o_mwe  += int'(mem_we);
                o_rwe  += int'(reg_we);
                if (state == 3'd5) begin
                    o_wbs  = wb_sel;
                    o_wsel = reg_wsel;
                end else begin
                    o_rwe_out += int'(reg_we);
                end
                if (state == 3'd4) begin
                    mem_ready = (mem_seen >= waits);
                    mem_seen++;
                end else begin
                    mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                if (noise) begin
                    step = 1'($urandom_range(0, 1));
                    if (state >= 3'd2) instruction = 8'($urandom_range(0, 255));
                end
                @(negedge clk);
            end
        end
        step = 1'b0;
        mem_ready = 1'b0;
        if (!done) o_timeout = 1'b1;
    endtask

    task automatic check_instr(input string tag, input logic [7:0] ins, input int lat,
                               input logic [7:0] epc, input logic [7:0] eret,
                               input int mreq, input int mwe, input int rwe,
                               input logic wbs, input logic [1:0] wsel);
        int bad_seq;
        int exp_s;
        chk({tag, ".timeout"}, 32'(o_timeout), 32'd0);
        chk({tag, ".latency"}, 32'(obs_q.size()), 32'(lat));
        bad_seq = 0;
        for (int i = 0; i < obs_q.size(); i++) begin
            if (i < 3) exp_s = i + 1;
            else if (i == lat - 1) exp_s = 5;
            else exp_s = 4;
            if (obs_q[i] != exp_s) bad_seq++;
        end
        chk({tag, ".state_seq_errs"}, 32'(bad_seq), 32'd0);
        chk({tag, ".mem_req_cycles"}, 32'(o_mreq), 32'(mreq));
        chk({tag, ".mem_we_cycles"}, 32'(o_mwe), 32'(mwe));
        chk({tag, ".reg_we_cycles"}, 32'(o_rwe), 32'(rwe));
        chk({tag, ".reg_we_outside_wb"}, 32'(o_rwe_out), 32'd0);
        chk({tag, ".busy_errs"}, 32'(o_busy_err), 32'd0);
        if (lat > 0) begin
            chk({tag, ".wb_sel"}, 32'(o_wbs), 32'(wbs));
            chk({tag, ".reg_wsel"}, 32'(o_wsel), 32'(wsel));
        end
        chk({tag, ".pc"}, 32'(pc), 32'(epc));
        chk({tag, ".retired"}, 32'(retired), 32'(eret));
        chk({tag, ".instr_q"}, 32'(instr_q), 32'(ins));
        chk({tag, ".state_idle"}, 32'(state), 32'd0);
    endtask

    initial begin
        int m_pc, m_ret, imm, op, waits, busy_cnt;
        logic [7:0] ins;

        //           rst   ins    wt lat pc      ret    mrq mwe rwe wbs   wsel
        vecs[0]  = '{1'b1, 8'h1B, 0, 4, 8'd1,   8'd1,  0,  0,  1,  1'b0, 2'd3};
        vecs[1]  = '{1'b1, 8'h44, 3, 8, 8'd1,   8'd1,  4,  0,  1,  1'b1, 2'd1};
        vecs[2]  = '{1'b1, 8'h84, 0, 5, 8'd1,   8'd1,  1,  1,  0,  1'b0, 2'd1};
        vecs[3]  = '{1'b1, 8'hC2, 0, 4, 8'd255, 8'd1,  0,  0,  0,  1'b0, 2'd0};
        vecs[4]  = '{1'b0, 8'hC2, 0, 4, 8'd254, 8'd2,  0,  0,  0,  1'b0, 2'd0};
        vecs[5]  = '{1'b0, 8'hC1, 0, 4, 8'd0,   8'd3,  0,  0,  0,  1'b0, 2'd0};
        vecs[6]  = '{1'b0, 8'hC3, 0, 4, 8'd0,   8'd4,  0,  0,  0,  1'b0, 2'd0};
        vecs[7]  = '{1'b0, 8'h27, 0, 4, 8'd1,   8'd5,  0,  0,  1,  1'b0, 2'd3};
        vecs[8]  = '{1'b0, 8'h6E, 1, 6, 8'd2,   8'd6,  2,  0,  1,  1'b1, 2'd3};
        vecs[9]  = '{1'b0, 8'hB8, 2, 7, 8'd3,   8'd7,  3,  3,  0,  1'b0, 2'd2};
        vecs[10] = '{1'b0, 8'hFF, 0, 4, 8'd3,   8'd8,  0,  0,  0,  1'b0, 2'd3};

        @(negedge clk);
        do_reset();
        chk("rst.state", 32'(state), 32'd0);
        chk("rst.pc", 32'(pc), 32'd0);
        chk("rst.instr_q", 32'(instr_q), 32'd0);
        chk("rst.retired", 32'(retired), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.mem_req", 32'(mem_req), 32'd0);
        chk("rst.mem_we", 32'(mem_we), 32'd0);
        chk("rst.reg_we", 32'(reg_we), 32'd0);

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rst) do_reset();
            run_one(vecs[i].ins, vecs[i].waits, 1'b0);
            check_instr($sformatf("vec%0d", i), vecs[i].ins, vecs[i].lat, vecs[i].pc,
                        vecs[i].ret, vecs[i].mreq, vecs[i].mwe, vecs[i].rwe,
                        vecs[i].wbs, vecs[i].wsel);
        end

        // Free-run three adds, drop run during the third, with step noise while busy
        do_reset();
        instruction = 8'h01;
        run = 1'b1;
        busy_cnt = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (state == 3'd0) break;
            busy_cnt++;
            step = 1'($urandom_range(0, 1));
            if (retired == 8'd2 && state == 3'd2) run = 1'b0;
        end
        step = 1'b0;
        run = 1'b0;
        chk("run.busy_cycles", 32'(busy_cnt), 32'd12);
        chk("run.retired", 32'(retired), 32'd3);
        chk("run.pc", 32'(pc), 32'd3);
        repeat (5) @(negedge clk);
        chk("run.stays_idle", 32'(state), 32'd0);
        chk("run.retired_after", 32'(retired), 32'd3);

        // Reset while stalled in MEM aborts without pc/retired update
        do_reset();
        run_one(8'h01, 0, 1'b0);
        chk("abort.pre_pc", 32'(pc), 32'd1);
        instruction = 8'h44;
        step = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        step = 1'b0;
        for (int cyc = 0; cyc < 20 && state != 3'd4; cyc++) @(negedge clk);
        @(negedge clk);
        chk("abort.in_mem", 32'(state), 32'd4);
        chk("abort.mem_req_high", 32'(mem_req), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort.state", 32'(state), 32'd0);
        chk("abort.pc", 32'(pc), 32'd0);
        chk("abort.retired", 32'(retired), 32'd0);
        chk("abort.mem_req", 32'(mem_req), 32'd0);
        chk("abort.instr_q", 32'(instr_q), 32'd0);
        @(negedge clk);
        chk("abort.idle_after", 32'(state), 32'd0);

        // Random instructions vs. instruction-level model; 260 retires wraps retired
        do_reset();
        m_pc = 0;
        m_ret = 0;
        for (int n = 0; n < 260; n++) begin
            ins = 8'($urandom_range(0, 255));
            waits = $urandom_range(0, 4);
            op = int'(ins[7:6]);
            run_one(ins, waits, 1'b1);
            imm = int'(ins[1:0]);
            if (imm >= 2) imm = imm - 4;
            m_pc = (m_pc + 1 + ((op == 3) ? imm : 0)) & 255;
            m_ret = (m_ret + 1) & 255;
            check_instr($sformatf("rnd%0d", n), ins,
                        (op == 1 || op == 2) ? 5 + waits : 4,
                        8'(m_pc), 8'(m_ret),
                        (op == 1 || op == 2) ? waits + 1 : 0,
                        (op == 2) ? waits + 1 : 0,
                        (op == 0 || op == 1) ? 1 : 0,
                        (op == 1),
                        (op == 0) ? ins[1:0] : ins[3:2]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
